// File: rtl/key_lookup_ctrl_if.sv
// Bundle of the lookup, hash-unit, key-table and response signals around key_lookup_ctrl.
// The controller connects through the slave modport; its surroundings use master.
interface key_lookup_ctrl_if #(
  parameter int KEY_W   = 128,
  parameter int HADDR_W = 20,
  parameter int TADDR_W = 14,
  parameter int DATA_W  = 64
);
  logic               lk_valid;
  logic               lk_ready;
  logic [KEY_W-1:0]   lk_key;

  logic               hash_req;
  logic [KEY_W-1:0]   hash_key;
  logic [HADDR_W-1:0] hash_addr;
  logic               hash_addr_valid;

  logic               tbl_rd_en;
  logic [TADDR_W-1:0] tbl_rd_addr;
  logic [KEY_W-1:0]   tbl_rd_key;
  logic [DATA_W-1:0]  tbl_rd_data;
  logic               tbl_rd_entry_vld;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_hit;
  logic               rsp_timeout;
  logic [TADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0]  rsp_data;

  modport slave (
    input  lk_valid, lk_key, hash_addr, hash_addr_valid,
           tbl_rd_key, tbl_rd_data, tbl_rd_entry_vld, rsp_ready,
    output lk_ready, hash_req, hash_key, tbl_rd_en, tbl_rd_addr,
           rsp_valid, rsp_hit, rsp_timeout, rsp_addr, rsp_data
  );

  modport master (
    output lk_valid, lk_key, hash_addr, hash_addr_valid,
           tbl_rd_key, tbl_rd_data, tbl_rd_entry_vld, rsp_ready,
    input  lk_ready, hash_req, hash_key, tbl_rd_en, tbl_rd_addr,
           rsp_valid, rsp_hit, rsp_timeout, rsp_addr, rsp_data
  );
endinterface

// File: rtl/key_lookup_ctrl.sv
// Key lookup controller: hashes a 128-bit key via the external hash unit, reads the
// key table at the returned address and reports hit/miss/timeout with the payload.
module key_lookup_ctrl #(
  parameter int KEY_W   = 128,
  parameter int HADDR_W = 20,
  parameter int TADDR_W = 14,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  key_lookup_ctrl_if.slave ctrl
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RD,
    CMP,
    RSP
  } state_t;

  state_t             state_q;
  logic [KEY_W-1:0]   key_q;
  logic [TADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               lk_ready_q;
  logic               hash_req_q;
  logic               tbl_rd_en_q;
  logic               rsp_valid_q;
  logic               rsp_hit_q;
  logic               rsp_timeout_q;
  logic [TADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0]  rsp_data_q;

  logic hit_d;
  assign hit_d = ctrl.tbl_rd_entry_vld && (ctrl.tbl_rd_key == key_q);

  // Only the low table-address bits of the hash are meaningful here.
  generate
    if (HADDR_W > TADDR_W) begin : g_hash_upper
      logic unused_hash_upper;
      assign unused_hash_upper = ^ctrl.hash_addr[HADDR_W-1:TADDR_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      key_q         <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      lk_ready_q    <= 1'b0;
      hash_req_q    <= 1'b0;
      tbl_rd_en_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
    end else begin
      hash_req_q  <= 1'b0;
      tbl_rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ctrl.lk_valid && lk_ready_q) begin
            key_q      <= ctrl.lk_key;
            lk_ready_q <= 1'b0;
            hash_req_q <= 1'b1;
            state_q    <= REQ;
          end else begin
            lk_ready_q <= 1'b1;
          end
        end
        REQ: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A result arriving on the final wait cycle still beats the timeout.
          if (ctrl.hash_addr_valid) begin
            addr_q      <= ctrl.hash_addr[TADDR_W-1:0];
            tbl_rd_en_q <= 1'b1;
            state_q     <= RD;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_hit_q     <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            state_q       <= RSP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RD: begin
          state_q <= CMP;
        end
        CMP: begin
          rsp_valid_q   <= 1'b1;
          rsp_timeout_q <= 1'b0;
          rsp_hit_q     <= hit_d;
          rsp_addr_q    <= addr_q;
          rsp_data_q    <= hit_d ? ctrl.tbl_rd_data : '0;
          state_q       <= RSP;
        end
        RSP: begin
          if (ctrl.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_hit_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            lk_ready_q    <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          lk_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign ctrl.lk_ready    = lk_ready_q;
  assign ctrl.hash_req    = hash_req_q;
  assign ctrl.hash_key    = key_q;
  assign ctrl.tbl_rd_en   = tbl_rd_en_q;
  assign ctrl.tbl_rd_addr = addr_q;
  assign ctrl.rsp_valid   = rsp_valid_q;
  assign ctrl.rsp_hit     = rsp_hit_q;
  assign ctrl.rsp_timeout = rsp_timeout_q;
  assign ctrl.rsp_addr    = rsp_addr_q;
  assign ctrl.rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_key_lookup_ctrl.sv
// Bench for key_lookup_ctrl: behavioural hash unit and key table, expected responses
// queued at issue time and checked by an independent monitor.
module tb_key_lookup_ctrl;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [127:0] key;
    logic         hit;
    logic         tmo;
    logic [13:0]  addr;
    logic [63:0]  data;
    int           lat;
    int           rdl;
  } exp_t;

  logic clk;
  logic reset;
  key_lookup_ctrl_if bus ();

  key_lookup_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .ctrl (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total = 0;
  int cyc = 0;
  exp_t q[$];

  logic [127:0] tk[16384];
  logic [63:0]  td[16384];
  bit           tv[16384];

  int hash_delay = 2;
  bit spur = 0;
  int rmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic evt_fail(input string name);
    total++;
    $display("FAIL %s: event seen when none expected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [19:0] hfun(input logic [127:0] k);
    return k[16 +: 20] ^ k[108 +: 20];
  endfunction

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [13:0] taddr(input logic [127:0] k);
    logic [19:0] h;
    h = hfun(k);
    return h[13:0];
  endfunction

  // Reference model: outcome decided by whether the hash answers inside the wait window.
  function automatic exp_t make_exp(input logic [127:0] k, input int d);
    exp_t e;
    logic [13:0] a;
    e.key = k;
    if (d == 0 || d > TIMEOUT) begin
      e.tmo = 1'b1; e.hit = 1'b0; e.addr = '0; e.data = '0;
      e.lat = TIMEOUT + 2; e.rdl = -1;
    end else begin
      a = taddr(k);
      e.tmo = 1'b0;
      e.addr = a;
      e.hit = tv[a] && (tk[a] == k);
      e.data = e.hit ? td[a] : 64'h0;
      e.lat = d + 4;
      e.rdl = d + 2;
    end
    return e;
  endfunction

  // Hash unit and key table models, driven mid-cycle.
  initial begin
    int hcnt;
    bit hpend;
    bit rd_pend;
    logic [127:0] hkey;
    logic [13:0] ra;
    hcnt = 0; hpend = 0; rd_pend = 0; hkey = '0; ra = '0;
    bus.hash_addr_valid = 1'b0;
    bus.hash_addr = '0;
    bus.tbl_rd_key = '0;
    bus.tbl_rd_data = '0;
    bus.tbl_rd_entry_vld = 1'b0;
    forever begin
      @(negedge clk);
      bus.hash_addr_valid = 1'b0;
      bus.hash_addr = 20'($urandom);
      if (reset) begin
        hpend = 0;
      end else begin
        if (hpend) begin
          hcnt--;
          if (hcnt == 0) begin
            bus.hash_addr_valid = 1'b1;
            bus.hash_addr = hfun(hkey);
            hpend = 0;
          end
        end
        if (spur) begin
          bus.hash_addr_valid = 1'b1;
          spur = 0;
        end
        if (bus.hash_req && hash_delay > 0) begin
          hpend = 1;
          hcnt = hash_delay;
          hkey = bus.hash_key;
        end
      end
      if (rd_pend) begin
        bus.tbl_rd_key = tk[ra];
        bus.tbl_rd_data = td[ra];
        bus.tbl_rd_entry_vld = tv[ra];
      end else begin
        bus.tbl_rd_key = rkey();
        bus.tbl_rd_data = {$urandom, $urandom};
        bus.tbl_rd_entry_vld = 1'($urandom);
      end
      rd_pend = bus.tbl_rd_en && !reset;
      ra = bus.tbl_rd_addr;
    end
  end

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.rsp_ready = 1'b1;
        1: bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented response and protocol event with the queue head.
  int acc = 0;
  int rdn = 0;
  bit active = 0;
  bit first = 0;
  always @(negedge clk) begin
    if (reset) begin
      active = 0;
    end else begin
      if (bus.lk_valid && bus.lk_ready) begin
        if (q.size() == 0) evt_fail("unexpected_accept");
        active = 1; acc = cyc; first = 1; rdn = 0;
      end
      if (bus.hash_req) begin
        if (!active || q.size() == 0) evt_fail("spurious_hash_req");
        else begin
          chk("hash_req_cycle", 128'(cyc - acc), 128'(1));
          chk("hash_key", bus.hash_key, q[0].key);
        end
      end
      if (bus.tbl_rd_en) begin
        rdn++;
        if (!active || q.size() == 0 || q[0].rdl < 0) evt_fail("spurious_tbl_rd");
        else begin
          chk("tbl_rd_cycle", 128'(cyc - acc), 128'(q[0].rdl));
          chk("tbl_rd_addr", 128'(bus.tbl_rd_addr), 128'(q[0].addr));
        end
      end
      if (bus.rsp_valid) begin
        if (!active || q.size() == 0) evt_fail("unexpected_rsp");
        else begin
          chk("rsp_hit", 128'(bus.rsp_hit), 128'(q[0].hit));
          chk("rsp_timeout", 128'(bus.rsp_timeout), 128'(q[0].tmo));
          chk("rsp_addr", 128'(bus.rsp_addr), 128'(q[0].addr));
          chk("rsp_data", 128'(bus.rsp_data), 128'(q[0].data));
          if (first) begin
            chk("rsp_latency", 128'(cyc - acc), 128'(q[0].lat));
            chk("tbl_rd_count", 128'(rdn), 128'(q[0].rdl >= 0 ? 1 : 0));
            first = 0;
          end
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            active = 0;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_lk_ready"}, 128'(bus.lk_ready), 128'(0));
    chk({tag, "_hash_req"}, 128'(bus.hash_req), 128'(0));
    chk({tag, "_hash_key"}, bus.hash_key, 128'(0));
    chk({tag, "_tbl_rd_en"}, 128'(bus.tbl_rd_en), 128'(0));
    chk({tag, "_tbl_rd_addr"}, 128'(bus.tbl_rd_addr), 128'(0));
    chk({tag, "_rsp_valid"}, 128'(bus.rsp_valid), 128'(0));
    chk({tag, "_rsp_hit"}, 128'(bus.rsp_hit), 128'(0));
    chk({tag, "_rsp_timeout"}, 128'(bus.rsp_timeout), 128'(0));
    chk({tag, "_rsp_addr"}, 128'(bus.rsp_addr), 128'(0));
    chk({tag, "_rsp_data"}, 128'(bus.rsp_data), 128'(0));
  endtask

  // Issue one lookup; returns just after the accepting edge.
  task automatic lookup(input logic [127:0] k, input int d);
    int n;
    @(posedge clk);
    #1;
    hash_delay = d;
    q.push_back(make_exp(k, d));
    bus.lk_key = k;
    bus.lk_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.lk_ready && n < 300);
    if (!bus.lk_ready) begin
      total++;
      $display("FAIL lookup_accept: lk_ready 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.lk_valid = 1'b0;
    bus.lk_key = rkey();
    $display("lookup key=%h delay=%0d", k, d);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL wait_done: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [13:0] a, input bit v, input logic [127:0] k,
                           input logic [63:0] dat);
    tv[a] = v; tk[a] = k; td[a] = dat;
  endtask

  initial begin
    logic [127:0] k1, k2, kr;
    logic [13:0] a;
    int n, rv, d;
    for (int i = 0; i < 16384; i++) begin
      tv[i] = 0; tk[i] = '0; td[i] = '0;
    end
    k1 = 128'h1 << 16;
    k2 = 128'h2 << 16;
    reset = 1'b1;
    bus.lk_valid = 1'b0;
    bus.lk_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Hit, invalid entry, key mismatch
    set_entry(14'h1, 1, k1, 64'hDEAD_BEEF_0000_0001);
    lookup(k1, 2); wait_done();
    tv[1] = 0;
    lookup(k1, 2); wait_done();
    set_entry(14'h1, 1, k2, 64'h1234);
    lookup(k1, 2); wait_done();

    // Hash never answers; answers on the last wait cycle; answers one cycle too late
    set_entry(14'h1, 1, k1, 64'hDEAD_BEEF_0000_0001);
    lookup(k1, 0); wait_done();
    lookup(k1, TIMEOUT); wait_done();
    lookup(k1, TIMEOUT + 1); wait_done();

    // Backpressure with a pending lookup held on the input, then back-to-back accept
    rmode = 2;
    set_entry(14'h2, 1, k2, 64'hCAFE_0000_0000_0002);
    lookup(k1, 2);
    q.push_back(make_exp(k2, 2));
    bus.lk_key = k2;
    bus.lk_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 50);
    chk("bp_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) spur = 1;
      @(negedge clk);
      chk("bp_lk_ready", 128'(bus.lk_ready), 128'(0));
      chk("bp_rsp_valid_held", 128'(bus.rsp_valid), 128'(1));
    end
    @(posedge clk);
    #1;
    rmode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rsp_valid && bus.rsp_ready) && n < 20);
    @(negedge clk);
    chk("b2b_lk_ready", 128'(bus.lk_ready), 128'(1));
    @(posedge clk);
    #1;
    bus.lk_valid = 1'b0;
    $display("lookup key=%h delay=2 (back-to-back)", k2);
    wait_done();

    // Spurious hash result while idle
    spur = 1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle_lk_ready", 128'(bus.lk_ready), 128'(1));
    end

    // Reset in cycle 4 of a lookup
    lookup(k1, 2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check_zero("midrst");
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    chk("midrst_no_rsp", 128'(n), 128'(0));
    lookup(k1, 2); wait_done();

    // Randomized lookups
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      kr = rkey();
      a = taddr(kr);
      rv = $urandom_range(0, 3);
      case (rv)
        0: set_entry(a, 1, kr, {$urandom, $urandom});
        1: set_entry(a, 0, kr, {$urandom, $urandom});
        2: set_entry(a, 1, kr ^ (128'h1 << $urandom_range(0, 127)), {$urandom, $urandom});
        default: ;
      endcase
      d = $urandom_range(0, TIMEOUT + 2);
      lookup(kr, d);
      wait_done();
    end
    rmode = 0;
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
